// File: rtl/board_display_scanner.sv
// rtl/board_display_scanner.sv - snapshots the mine/cleared board and streams one display code per beat
//
// Purpose: on a display request the block captures the mine map, the cleared map and the
// gameover flag, then streams the 25 cells in index order over a valid/ready handshake.
// Once the last cell has been transferred it raises a one-cycle done pulse.
//
// Ports:
//   in_clka            clock, rising edge
//   in_restart         synchronous active-high reset
//   in_display         start request, only honoured while idle
//   in_mines           mine map, bit i = mine at cell i
//   in_cleared         cleared-cell map
//   in_gameover        reveal mines when set at snapshot time
//   in_ready           renderer accepts the current beat
//   out_valid          beat valid
//   out_cell_idx       cell index of the current beat
//   out_cell_code      0..8 neighbour count, 9 hidden, 10 mine
//   out_last           beat carries the final cell
//   out_busy           scan or completion in progress
//   out_display_done   one-cycle completion pulse
//   out_cleared_count  beats in this scan whose code was 0..8
module board_display_scanner #(
    parameter  int ROWS  = 5,
    parameter  int COLS  = 5,
    localparam int CELLS = ROWS * COLS,
    localparam int IW    = $clog2(CELLS)
) (
    input  logic             in_clka,
    input  logic             in_restart,
    input  logic             in_display,
    input  logic [CELLS-1:0] in_mines,
    input  logic [CELLS-1:0] in_cleared,
    input  logic             in_gameover,
    input  logic             in_ready,
    output logic             out_valid,
    output logic [IW-1:0]    out_cell_idx,
    output logic [3:0]       out_cell_code,
    output logic             out_last,
    output logic             out_busy,
    output logic             out_display_done,
    output logic [IW-1:0]    out_cleared_count
);

    localparam logic [IW-1:0] LAST_IDX  = IW'(CELLS - 1);
    localparam logic [3:0]    CODE_HIDE = 4'd9;
    localparam logic [3:0]    CODE_MINE = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CELLS-1:0] r_mines_snap;
    logic [CELLS-1:0] r_cleared_snap;
    logic             r_gameover_snap;

    logic [IW-1:0]    w_code_idx;
    logic [CELLS-1:0] w_code_mines;
    logic [CELLS-1:0] w_code_cleared;
    logic             w_code_gameover;
    logic [3:0]       w_code;

    // Neighbour positions are resolved against constant row/column tables so no
    // divider is built for the variable index.
    function automatic logic [3:0] f_cell_code(
        input logic [IW-1:0]    idx,
        input logic [CELLS-1:0] mines,
        input logic [CELLS-1:0] cleared,
        input logic             gameover
    );
        int         row;
        int         col;
        logic [3:0] cnt;
        logic       is_mine;
        logic       is_clr;
        row     = 0;
        col     = 0;
        cnt     = 4'd0;
        is_mine = 1'b0;
        is_clr  = 1'b0;
        for (int k = 0; k < CELLS; k++) begin
            if (idx == IW'(k)) begin
                row     = k / COLS;
                col     = k % COLS;
                is_mine = mines[k];
                is_clr  = cleared[k];
            end
        end
        for (int j = 0; j < CELLS; j++) begin
            if (mines[j] && (j / COLS) >= row - 1 && (j / COLS) <= row + 1
                         && (j % COLS) >= col - 1 && (j % COLS) <= col + 1
                         && !((j / COLS) == row && (j % COLS) == col)) begin
                cnt = cnt + 4'd1;
            end
        end
        if (gameover && is_mine) begin
            return CODE_MINE;
        end else if (!is_clr) begin
            return CODE_HIDE;
        end else if (is_mine) begin
            return CODE_MINE;
        end
        return cnt;
    endfunction

    // One shared code generator: at start it looks at the live inputs for cell 0,
    // during the scan it precomputes the next cell from the snapshot so the code
    // can be registered together with the index.
    always_comb begin
        w_code_idx      = '0;
        w_code_mines    = r_mines_snap;
        w_code_cleared  = r_cleared_snap;
        w_code_gameover = r_gameover_snap;
        if (r_state == ST_IDLE) begin
            w_code_mines    = in_mines;
            w_code_cleared  = in_cleared;
            w_code_gameover = in_gameover;
        end else begin
            w_code_idx = out_cell_idx + IW'(1);
        end
        w_code = f_cell_code(w_code_idx, w_code_mines, w_code_cleared, w_code_gameover);
    end

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            r_state           <= ST_IDLE;
            r_mines_snap      <= '0;
            r_cleared_snap    <= '0;
            r_gameover_snap   <= 1'b0;
            out_valid         <= 1'b0;
            out_cell_idx      <= '0;
            out_cell_code     <= 4'd0;
            out_last          <= 1'b0;
            out_busy          <= 1'b0;
            out_display_done  <= 1'b0;
            out_cleared_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    out_display_done <= 1'b0;
                    if (in_display) begin
                        r_mines_snap      <= in_mines;
                        r_cleared_snap    <= in_cleared;
                        r_gameover_snap   <= in_gameover;
                        out_valid         <= 1'b1;
                        out_cell_idx      <= '0;
                        out_cell_code     <= w_code;
                        out_last          <= (LAST_IDX == '0);
                        out_busy          <= 1'b1;
                        out_cleared_count <= '0;
                        r_state           <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (in_ready) begin
                        if (out_cell_code <= 4'd8) begin
                            out_cleared_count <= out_cleared_count + IW'(1);
                        end
                        if (out_cell_idx == LAST_IDX) begin
                            out_valid        <= 1'b0;
                            out_last         <= 1'b0;
                            out_display_done <= 1'b1;
                            r_state          <= ST_DONE;
                        end else begin
                            out_cell_idx  <= out_cell_idx + IW'(1);
                            out_cell_code <= w_code;
                            out_last      <= (out_cell_idx + IW'(1) == LAST_IDX);
                        end
                    end
                end
                ST_DONE: begin
                    out_display_done <= 1'b0;
                    out_busy         <= 1'b0;
                    r_state          <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_display_scanner.sv
// tb/tb_board_display_scanner.sv - self-checking bench for board_display_scanner
module tb_board_display_scanner;

    localparam int ROWS  = 5;
    localparam int COLS  = 5;
    localparam int CELLS = ROWS * COLS;

    logic             clk = 1'b0;
    logic             in_restart = 1'b1;
    logic             in_display = 1'b0;
    logic [CELLS-1:0] in_mines = '0;
    logic [CELLS-1:0] in_cleared = '0;
    logic             in_gameover = 1'b0;
    logic             in_ready = 1'b0;
    logic             out_valid;
    logic [4:0]       out_cell_idx;
    logic [3:0]       out_cell_code;
    logic             out_last;
    logic             out_busy;
    logic             out_display_done;
    logic [4:0]       out_cleared_count;

    int checks = 0;
    int errors = 0;

    board_display_scanner #(.ROWS(ROWS), .COLS(COLS)) dut (
        .in_clka           (clk),
        .in_restart        (in_restart),
        .in_display        (in_display),
        .in_mines          (in_mines),
        .in_cleared        (in_cleared),
        .in_gameover       (in_gameover),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_cell_idx      (out_cell_idx),
        .out_cell_code     (out_cell_code),
        .out_last          (out_last),
        .out_busy          (out_busy),
        .out_display_done  (out_display_done),
        .out_cleared_count (out_cleared_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference display code: rule priority then a clipped 3x3 neighbourhood walk.
    function automatic int ref_code(input logic [CELLS-1:0] m, input logic [CELLS-1:0] c,
                                    input logic g, input int i);
        int r;
        int col;
        int n;
        if (g && m[i]) return 10;
        if (!c[i]) return 9;
        if (m[i]) return 10;
        r   = i / COLS;
        col = i % COLS;
        n   = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS
                    && col + dc >= 0 && col + dc < COLS && m[(r + dr) * COLS + col + dc]) begin
                    n++;
                end
            end
        end
        return n;
    endfunction

    // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
    // Inputs are scrambled throughout the scan to prove the snapshot is used.
    task automatic run_scan(input string name, input logic [CELLS-1:0] m,
                            input logic [CELLS-1:0] c, input logic g, input int mode);
        int  exp_idx;
        int  cyc;
        int  exp_cnt;
        logic rdy;
        exp_cnt = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (ref_code(m, c, g, i) <= 8) exp_cnt++;
        end
        in_mines    = m;
        in_cleared  = c;
        in_gameover = g;
        in_display  = 1'b1;
        tick();
        in_display = 1'b0;
        exp_idx = 0;
        cyc     = 0;
        while (exp_idx < CELLS && cyc < 400) begin
            chk({name, "_valid"}, int'(out_valid), 1);
            chk({name, "_idx"}, int'(out_cell_idx), exp_idx);
            chk({name, "_code"}, int'(out_cell_code), ref_code(m, c, g, exp_idx));
            chk({name, "_last"}, int'(out_last), int'(exp_idx == CELLS - 1));
            chk({name, "_busy"}, int'(out_busy), 1);
            chk({name, "_done_early"}, int'(out_display_done), 0);
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            else rdy = 1'($urandom_range(0, 1));
            in_ready    = rdy;
            in_mines    = (exp_idx == 5) ? '1 : CELLS'($urandom);
            in_cleared  = CELLS'($urandom);
            in_gameover = 1'($urandom_range(0, 1));
            in_display  = 1'($urandom_range(0, 1));
            tick();
            if (rdy) exp_idx++;
            cyc++;
        end
        if (exp_idx < CELLS) chk({name, "_scan_timeout"}, exp_idx, CELLS);
        if (mode == 0) chk({name, "_cycles"}, cyc, CELLS);
        in_display = 1'b0;
        chk({name, "_done_valid"}, int'(out_valid), 0);
        chk({name, "_done_pulse"}, int'(out_display_done), 1);
        chk({name, "_done_busy"}, int'(out_busy), 1);
        chk({name, "_count"}, int'(out_cleared_count), exp_cnt);
        tick();
        chk({name, "_post_done"}, int'(out_display_done), 0);
        chk({name, "_post_busy"}, int'(out_busy), 0);
        chk({name, "_post_valid"}, int'(out_valid), 0);
        chk({name, "_count_hold"}, int'(out_cleared_count), exp_cnt);
    endtask

    initial begin
        logic [CELLS-1:0] m;
        logic [CELLS-1:0] c;
        int               exp_idx;

        // Reset from power-up
        in_restart = 1'b1;
        tick();
        in_restart = 1'b0;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_idx", int'(out_cell_idx), 0);
        chk("rst_code", int'(out_cell_code), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_busy", int'(out_busy), 0);
        chk("rst_done", int'(out_display_done), 0);
        chk("rst_count", int'(out_cleared_count), 0);
        tick();
        chk("idle_valid", int'(out_valid), 0);

        // Centre mine
        m = CELLS'(1) << 12;
        run_scan("centre", m, ~m, 1'b0, 0);

        // Edges, no wrap between cell 4 and cell 5
        m = (CELLS'(1) << 0) | (CELLS'(1) << 1) | (CELLS'(1) << 5);
        c = (CELLS'(1) << 4) | (CELLS'(1) << 6) | (CELLS'(1) << 9);
        chk("edge_model_c6", ref_code(m, c, 1'b0, 6), 3);
        chk("edge_model_c4", ref_code(m, c, 1'b0, 4), 0);
        run_scan("edges", m, c, 1'b0, 0);

        // Backpressure on the centre-mine board
        m = CELLS'(1) << 12;
        run_scan("bp", m, ~m, 1'b0, 1);

        // Gameover reveal with mid-scan input changes
        m = (CELLS'(1) << 3) | (CELLS'(1) << 20);
        run_scan("gameover", m, '0, 1'b1, 2);

        // Random boards and random ready
        for (int t = 0; t < 6; t++) begin
            run_scan("rand", CELLS'($urandom), CELLS'($urandom), 1'($urandom_range(0, 1)), 2);
        end

        // Abort: display ignored mid-scan, reset at idx 10 kills the scan
        m = CELLS'($urandom);
        c = CELLS'($urandom);
        in_mines    = m;
        in_cleared  = c;
        in_gameover = 1'b0;
        in_ready    = 1'b1;
        in_display  = 1'b1;
        tick();
        exp_idx = 0;
        while (exp_idx < 10) begin
            chk("abort_idx", int'(out_cell_idx), exp_idx);
            chk("abort_code", int'(out_cell_code), ref_code(m, c, 1'b0, exp_idx));
            in_display = (exp_idx == 7);
            tick();
            exp_idx++;
        end
        in_display = 1'b0;
        chk("abort_idx10", int'(out_cell_idx), 10);
        chk("abort_valid10", int'(out_valid), 1);
        in_restart = 1'b1;
        tick();
        in_restart = 1'b0;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(out_busy), 0);
        chk("abort_done", int'(out_display_done), 0);
        chk("abort_count", int'(out_cleared_count), 0);
        chk("abort_idx_clr", int'(out_cell_idx), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", int'(out_display_done), 0);
            chk("abort_idle_valid", int'(out_valid), 0);
        end
        run_scan("restart", CELLS'($urandom), CELLS'($urandom), 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/board_display_scanner.md
Name: board_display_scanner

Overview:
- Downstream consumer of the game core's display request, mine map and cleared map.
- On each display request it snapshots the 25-cell board and streams one cell per beat over a valid/ready handshake to the board renderer.
- Each beat carries a display code: neighbour-mine count, hidden, or mine.
- After the last cell it returns a one-cycle done pulse to the game FSM.

Parameters:
- ROWS, 5, board rows.
- COLS, 5, board columns; CELLS = ROWS*COLS = 25. Cell index i is row i/COLS, column i%COLS.

Ports:
- in_clka  input  1  clock; rising edge only.
- in_restart  input  1  reset: synchronous, active-high.
- in_display  input  1  start request; sampled only in IDLE.
- in_mines  input  25  mine map; bit i = 1 means mine at cell i.
- in_cleared  input  25  cleared-cell map.
- in_gameover  input  1  when set at snapshot time, mines are revealed.
- in_ready  input  1  renderer accepts the current beat.
- out_valid  output  1  beat valid.
- out_cell_idx  output  5  cell index, 0..24.
- out_cell_code  output  4  0..8 = neighbour count, 9 = hidden, 10 = mine.
- out_last  output  1  high with the beat for cell 24.
- out_busy  output  1  high in SCAN and DONE.
- out_display_done  output  1  one-cycle completion pulse.
- out_cleared_count  output  5  count of beats in the scan with code 0..8.

Behaviour:
- Reset, at the rising edge with in_restart=1: state IDLE. All outputs 0. Snapshot registers 0. Reset takes priority over every other event, including mid-scan. An aborted scan emits no done pulse.
- IDLE → SCAN: at an edge with in_display=1:
  - capture in_mines, in_cleared and in_gameover into snapshot registers;
  - set idx = 0 and clear out_cleared_count.
  - out_valid is 1 in the following cycle, so latency is one cycle.
- SCAN:
  - out_valid = 1. out_cell_idx = idx. out_cell_code is computed from the snapshot only; input changes during a scan have no effect.
  - A transfer happens on an edge with out_valid & in_ready. On transfer, idx increments, and out_cleared_count increments if the code is 0..8.
  - While in_ready = 0, idx and code hold stable.
  - out_last = (idx == 24).
  - A transfer with idx 24 moves the state to DONE.
- DONE: out_display_done = 1 and out_valid = 0 for exactly one cycle, then IDLE.
- in_display in SCAN or DONE is ignored. out_cleared_count holds its value after DONE until the next scan starts.
- Code priority, per cell:
  1. gameover_snap & mine → 10;
  2. !cleared → 9;
  3. cleared & mine → 10;
  4. otherwise the count of mines among the 8 neighbours → 0..8.
- Neighbour rules: clip at board edges with no wrap, so cell 4 does not neighbour cell 5. The cell itself is excluded.
- Control: FSM states IDLE, SCAN, DONE. Outputs are driven only from state, idx and snapshot; no combinational path from in_ready to the outputs.
- Throughput: 25 beats in 25 cycles when in_ready is held high. Scan to done pulse takes 26 cycles.

Test Plan:
1. Reset: assert in_restart for 1 cycle from an unknown state → all outputs 0, out_busy 0. Then pulse in_display → out_valid=1, idx=0 on the next cycle.
2. Centre mine:
   - Stimulus: mines={12}, cleared = all cells except 12, gameover=0, ready=1.
   - Required: 25 consecutive beats, idx 0..24.
   - Codes: cells 6,7,8,11,13,16,17,18 = 1; cell 12 = 9; all other cells = 0.
   - out_last on idx 24, out_display_done on the next cycle, out_cleared_count = 24.
3. Edges and no wrap:
   - Stimulus: mines={0,1,5}, cleared={4,6,9}.
   - Required codes: cell 6 = 3, cell 4 = 0, cell 9 = 0, all other cells = 9.
   - out_cleared_count = 3.
4. Backpressure: repeat scenario 2 with in_ready following the pattern 1,0,0,1 repeated → idx and code stable while stalled. Exactly 25 transfers, no index skipped or repeated. Done pulse only after the idx-24 transfer.
5. Gameover and snapshot:
   - Stimulus: mines={3,20}, cleared=0, gameover=1. At idx 5, change in_mines to all ones.
   - Required: cells 3 and 20 = 10, all other cells = 9. The mid-scan change has no effect.
   - out_cleared_count = 0.
6. Abort and ignore:
   - Pulse in_display at idx 7 → ignored.
   - Assert in_restart at idx 10 → next cycle out_valid=0, out_busy=0. No done pulse. A following in_display restarts the scan at idx 0.
